// File: rtl/norm_shift_feeder.sv
// Leading-zero counter feeding a left barrel shifter, with a 2-entry output FIFO.
// Optional macro NORM_SHIFT_FEEDER_STATS_EN adds accepted-word and zero-word counters.
module norm_shift_feeder #(
    parameter  int WIDTH = 8,
    localparam int SW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [SW-1:0]    out_shft,
    output logic             out_zero
`ifdef NORM_SHIFT_FEEDER_STATS_EN
    ,
    output logic [31:0]      stat_words,
    output logic [31:0]      stat_zeros
`endif
);

    logic [WIDTH-1:0] mem_data_reg [2];
    logic [SW-1:0]    mem_shft_reg [2];
    logic             mem_zero_reg [2];
    logic [1:0]       count_reg, count_next;
    logic             rd_ptr_reg, rd_ptr_next;
    logic             wr_ptr_reg, wr_ptr_next;
    logic [WIDTH-1:0] out_data_reg;
    logic [SW-1:0]    out_shft_reg;
    logic             out_zero_reg;

    logic [SW-1:0]    lzc_shft;
    logic             lzc_zero;
    logic             push, pop, head_from_push;

    // Last set bit seen while scanning upward is the most significant one.
    always_comb begin
        lzc_shft = '0;
        lzc_zero = (in_data == '0);
        for (int i = 0; i < WIDTH; i++) begin
            if (in_data[i]) begin
                lzc_shft = SW'(WIDTH - 1 - i);
            end
        end
    end

    assign in_ready  = (count_reg != 2'd2);
    assign out_valid = (count_reg != 2'd0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        rd_ptr_next = rd_ptr_reg ^ pop;
        wr_ptr_next = wr_ptr_reg ^ push;
        count_next  = count_reg;
        unique case ({push, pop})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
        // The next head is the incoming word when it lands in the slot the read pointer moves to.
        head_from_push = push && (wr_ptr_reg == rd_ptr_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg    <= 2'd0;
            rd_ptr_reg   <= 1'b0;
            wr_ptr_reg   <= 1'b0;
            out_data_reg <= '0;
            out_shft_reg <= '0;
            out_zero_reg <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                mem_data_reg[i] <= '0;
                mem_shft_reg[i] <= '0;
                mem_zero_reg[i] <= 1'b0;
            end
        end else begin
            count_reg  <= count_next;
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            if (push) begin
                mem_data_reg[wr_ptr_reg] <= in_data;
                mem_shft_reg[wr_ptr_reg] <= lzc_shft;
                mem_zero_reg[wr_ptr_reg] <= lzc_zero;
            end
            // Output registers only move when a head exists afterwards, so they hold when empty.
            if (count_next != 2'd0) begin
                if (head_from_push) begin
                    out_data_reg <= in_data;
                    out_shft_reg <= lzc_shft;
                    out_zero_reg <= lzc_zero;
                end else begin
                    out_data_reg <= mem_data_reg[rd_ptr_next];
                    out_shft_reg <= mem_shft_reg[rd_ptr_next];
                    out_zero_reg <= mem_zero_reg[rd_ptr_next];
                end
            end
        end
    end

    assign out_data = out_data_reg;
    assign out_shft = out_shft_reg;
    assign out_zero = out_zero_reg;

`ifdef NORM_SHIFT_FEEDER_STATS_EN
    logic [31:0] stat_words_reg;
    logic [31:0] stat_zeros_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_words_reg <= 32'd0;
            stat_zeros_reg <= 32'd0;
        end else if (push) begin
            stat_words_reg <= stat_words_reg + 32'd1;
            if (lzc_zero) begin
                stat_zeros_reg <= stat_zeros_reg + 32'd1;
            end
        end
    end

    assign stat_words = stat_words_reg;
    assign stat_zeros = stat_zeros_reg;
`endif

endmodule

// File: tb/tb_norm_shift_feeder.sv
// Self-checking bench for norm_shift_feeder at WIDTH=8: queue model plus directed literal checks.
module tb_norm_shift_feeder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = 8'h00;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic [2:0] out_shft;
    logic       out_zero;
`ifdef NORM_SHIFT_FEEDER_STATS_EN
    logic [31:0] stat_words;
    logic [31:0] stat_zeros;
`endif

    int n_vec = 0;
    int n_err = 0;

    norm_shift_feeder #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_shft  (out_shft),
        .out_zero  (out_zero)
`ifdef NORM_SHIFT_FEEDER_STATS_EN
        ,
        .stat_words(stat_words),
        .stat_zeros(stat_zeros)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] d;
        int         shft;
        bit         zero;
    } exp_t;

    exp_t q[$];

    // Reference count: walk down from the MSB until a one is found.
    function automatic int ref_lzc(logic [7:0] d);
        int n;
        if (d == 8'h00) return 0;
        n = 0;
        while (d[7 - n] == 1'b0) n++;
        return n;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: at most two words in flight, FIFO order, ready decided from the occupancy before the edge.
    always @(posedge clk or negedge rst_n) begin
        automatic bit do_pop;
        automatic bit do_push;
        automatic exp_t e;
        if (!rst_n) begin
            q.delete();
        end else begin
            do_pop  = (q.size() != 0) && out_ready;
            do_push = in_valid && (q.size() < 2);
            if (do_pop) begin
                $display("emit   data=%02h shft=%0d zero=%0d", q[0].d, q[0].shft, q[0].zero);
                void'(q.pop_front());
            end
            if (do_push) begin
                e.d = in_data;
                e.shft = ref_lzc(in_data);
                e.zero = (in_data == 8'h00);
                $display("accept data=%02h", in_data);
                q.push_back(e);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("model_in_ready", 32'(in_ready), 32'(q.size() < 2));
            if (q.size() != 0) begin
                chk("model_out_data", 32'(out_data), 32'(q[0].d));
                chk("model_out_shft", 32'(out_shft), 32'(q[0].shft));
                chk("model_out_zero", 32'(out_zero), 32'(q[0].zero));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic single(logic [7:0] d, int exp_shft, bit exp_zero);
        in_valid = 1'b1;
        in_data  = d;
        out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        chk("single_valid", 32'(out_valid), 32'd1);
        chk("single_data", 32'(out_data), 32'(d));
        chk("single_shft", 32'(out_shft), 32'(exp_shft));
        chk("single_zero", 32'(out_zero), 32'(exp_zero));
        cyc();
        chk("single_drained", 32'(out_valid), 32'd0);
    endtask

    logic [7:0] stream_tab [16] = '{8'h01, 8'h80, 8'h3c, 8'h00, 8'h17, 8'h42, 8'h09, 8'hff,
                                    8'h20, 8'h05, 8'h10, 8'h7e, 8'h02, 8'hc3, 8'h04, 8'h08};

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_shft", 32'(out_shft), 32'd0);
        chk("rst_out_zero", 32'(out_zero), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();

        // Basic and extremes
        single(8'b0001_0110, 3, 1'b0);
        single(8'h80, 0, 1'b0);
        single(8'h01, 7, 1'b0);
        single(8'h00, 0, 1'b1);

        // Back-pressure
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h40;
        cyc();
        chk("bp_ready_after_1", 32'(in_ready), 32'd1);
        in_data = 8'h08;
        cyc();
        chk("bp_ready_full", 32'(in_ready), 32'd0);
        chk("bp_head_data", 32'(out_data), 32'h40);
        chk("bp_head_shft", 32'(out_shft), 32'd1);
        in_data = 8'h02;
        cyc();
        chk("bp_held_ready", 32'(in_ready), 32'd0);
        chk("bp_held_data", 32'(out_data), 32'h40);
        chk("bp_held_shft", 32'(out_shft), 32'd1);
        out_ready = 1'b1;
        cyc();
        chk("bp_pop1_data", 32'(out_data), 32'h08);
        chk("bp_pop1_shft", 32'(out_shft), 32'd4);
        chk("bp_pop1_ready", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0;
        chk("bp_pop2_data", 32'(out_data), 32'h02);
        chk("bp_pop2_shft", 32'(out_shft), 32'd6);
        chk("bp_pop2_valid", 32'(out_valid), 32'd1);
        cyc();
        chk("bp_empty", 32'(out_valid), 32'd0);

        // Streaming
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = stream_tab[i];
            cyc();
            chk("stream_ready", 32'(in_ready), 32'd1);
            chk("stream_data", 32'(out_data), 32'(stream_tab[i]));
        end
        in_valid = 1'b0;
        cyc();
        chk("stream_drained", 32'(out_valid), 32'd0);

        // Reset mid-operation with two words buffered
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 8'h11;
        cyc();
        in_data = 8'h22;
        cyc();
        in_valid = 1'b0;
        chk("pre_rst_full", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_data", 32'(out_data), 32'd0);
        cyc();
        @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("post_rst_no_stale", 32'(out_valid), 32'd0);
        end

`ifdef NORM_SHIFT_FEEDER_STATS_EN
        chk("stats_cleared_words", stat_words, 32'd0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = (i == 1 || i == 3) ? 8'h00 : 8'(8'h10 + i);
            cyc();
        end
        in_valid = 1'b0;
        cyc();
        chk("stat_words", stat_words, 32'd5);
        chk("stat_zeros", stat_zeros, 32'd2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("stat_words_rst", stat_words, 32'd0);
        chk("stat_zeros_rst", stat_zeros, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
